// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC register, next-PC selection, IF/ID pipeline register,
// RUN/HOLD stall tracking and saturating fetch/stall counters.
module fetch_unit #(
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic        clk,
    input  logic        reset,
    output logic [7:0]  i_address,
    input  logic [31:0] instruction,
    input  logic        stall,
    input  logic        flush,
    input  logic        branch_taken,
    input  logic [7:0]  branch_target,
    input  logic        jump,
    input  logic [7:0]  jump_target,
    output logic [31:0] if_id_instruction,
    output logic [7:0]  if_id_pc_plus4,
    output logic        if_id_valid,
    output logic [15:0] fetch_count,
    output logic [15:0] stall_count,
    output logic        in_hold
);

    typedef enum logic {
        RUN  = 1'b0,
        HOLD = 1'b1
    } state_e;

    localparam logic [7:0] RESET_PC_ALIGNED = RESET_PC & 8'hFC;

    state_e      state_q, state_d;
    logic [7:0]  pc_q, pc_d;
    logic [31:0] ifIdInstr_q, ifIdInstr_d;
    logic [7:0]  ifIdPcPlus4_q, ifIdPcPlus4_d;
    logic        ifIdValid_q, ifIdValid_d;
    logic [15:0] fetchCount_q, fetchCount_d;
    logic [15:0] stallCount_q, stallCount_d;
    logic [7:0]  pcPlus4;
    logic        redirect;
    logic        loadValid;

    // A redirect comes from an older instruction, so it beats stall for both PC and IF/ID.
    always_comb begin
        pcPlus4       = pc_q + 8'd4;
        redirect      = branch_taken | jump;
        loadValid     = !redirect && !flush && !stall;
        pc_d          = pcPlus4;
        ifIdInstr_d   = ifIdInstr_q;
        ifIdPcPlus4_d = ifIdPcPlus4_q;
        ifIdValid_d   = ifIdValid_q;
        fetchCount_d  = fetchCount_q;
        stallCount_d  = stallCount_q;
        state_d       = RUN;

        if (branch_taken) begin
            pc_d = branch_target & 8'hFC;
        end else if (jump) begin
            pc_d = jump_target & 8'hFC;
        end else if (stall) begin
            pc_d = pc_q;
        end

        if (redirect || flush) begin
            ifIdInstr_d   = 32'h0;
            ifIdPcPlus4_d = 8'h00;
            ifIdValid_d   = 1'b0;
        end else if (!stall) begin
            ifIdInstr_d   = instruction;
            ifIdPcPlus4_d = pcPlus4;
            ifIdValid_d   = 1'b1;
        end

        if (loadValid && fetchCount_q != 16'hFFFF) begin
            fetchCount_d = fetchCount_q + 16'd1;
        end
        if (state_q == HOLD && stallCount_q != 16'hFFFF) begin
            stallCount_d = stallCount_q + 16'd1;
        end

        if (stall && !redirect) begin
            state_d = HOLD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= RUN;
            pc_q          <= RESET_PC_ALIGNED;
            ifIdInstr_q   <= 32'h0;
            ifIdPcPlus4_q <= 8'h00;
            ifIdValid_q   <= 1'b0;
            fetchCount_q  <= 16'h0;
            stallCount_q  <= 16'h0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            ifIdInstr_q   <= ifIdInstr_d;
            ifIdPcPlus4_q <= ifIdPcPlus4_d;
            ifIdValid_q   <= ifIdValid_d;
            fetchCount_q  <= fetchCount_d;
            stallCount_q  <= stallCount_d;
        end
    end

    assign i_address         = pc_q;
    assign if_id_instruction = ifIdInstr_q;
    assign if_id_pc_plus4    = ifIdPcPlus4_q;
    assign if_id_valid       = ifIdValid_q;
    assign fetch_count       = fetchCount_q;
    assign stall_count       = stallCount_q;
    assign in_hold           = (state_q == HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; instruction memory word at address A is 32'hC0DE0000 | A.
module tb_fetch_unit;

    logic        clk;
    logic        reset;
    logic [7:0]  i_address;
    logic [31:0] instruction;
    logic        stall;
    logic        flush;
    logic        branch_taken;
    logic [7:0]  branch_target;
    logic        jump;
    logic [7:0]  jump_target;
    logic [31:0] if_id_instruction;
    logic [7:0]  if_id_pc_plus4;
    logic        if_id_valid;
    logic [15:0] fetch_count;
    logic [15:0] stall_count;
    logic        in_hold;

    int checks;
    int failures;

    fetch_unit #(.RESET_PC(8'h00)) dut (
        .clk               (clk),
        .reset             (reset),
        .i_address         (i_address),
        .instruction       (instruction),
        .stall             (stall),
        .flush             (flush),
        .branch_taken      (branch_taken),
        .branch_target     (branch_target),
        .jump              (jump),
        .jump_target       (jump_target),
        .if_id_instruction (if_id_instruction),
        .if_id_pc_plus4    (if_id_pc_plus4),
        .if_id_valid       (if_id_valid),
        .fetch_count       (fetch_count),
        .stall_count       (stall_count),
        .in_hold           (in_hold)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign instruction = 32'hC0DE0000 | {24'h0, i_address};

    // Outputs are sampled 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic rst, input logic stl, input logic fl,
                                 input logic br, input logic [7:0] brT,
                                 input logic jp, input logic [7:0] jpT);
        reset         = rst;
        stall         = stl;
        flush         = fl;
        branch_taken  = br;
        branch_target = brT;
        jump          = jp;
        jump_target   = jpT;
    endtask

    task automatic test_reset();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 8'h40, 1'b1, 8'h80);
        step();
        checks++; if (i_address !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc: got %h expected 00", i_address); end
        checks++; if (if_id_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_valid: got %b expected 0", if_id_valid); end
        checks++; if (if_id_instruction !== 32'h0) begin failures++; $display("[TB] FAIL reset_instr: got %h expected 0", if_id_instruction); end
        checks++; if (if_id_pc_plus4 !== 8'h00) begin failures++; $display("[TB] FAIL reset_pc4: got %h expected 00", if_id_pc_plus4); end
        checks++; if (fetch_count !== 16'd0 || stall_count !== 16'd0) begin failures++; $display("[TB] FAIL reset_counts: got %0d/%0d expected 0/0", fetch_count, stall_count); end
        checks++; if (in_hold !== 1'b0) begin failures++; $display("[TB] FAIL reset_hold: got %b expected 0", in_hold); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
    endtask

    task automatic test_sequential();
        logic [31:0] expInstr;
        for (int k = 1; k <= 4; k++) begin
            step();
            expInstr = 32'hC0DE0000 + 32'(4 * (k - 1));
            checks++; if (i_address !== 8'(4 * k)) begin failures++; $display("[TB] FAIL seq_pc%0d: got %h expected %h", k, i_address, 8'(4 * k)); end
            checks++; if (if_id_instruction !== expInstr || if_id_valid !== 1'b1) begin failures++; $display("[TB] FAIL seq_instr%0d: got %h/%b expected %h/1", k, if_id_instruction, if_id_valid, expInstr); end
            checks++; if (if_id_pc_plus4 !== 8'(4 * k)) begin failures++; $display("[TB] FAIL seq_pc4_%0d: got %h expected %h", k, if_id_pc_plus4, 8'(4 * k)); end
        end
        checks++; if (fetch_count !== 16'd4) begin failures++; $display("[TB] FAIL seq_fetch_count: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_stall();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        step();
        checks++; if (i_address !== 8'h08 || if_id_instruction !== 32'hC0DE0004) begin failures++; $display("[TB] FAIL stall_setup: got %h/%h expected 08/c0de0004", i_address, if_id_instruction); end
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            checks++; if (i_address !== 8'h08) begin failures++; $display("[TB] FAIL stall_pc%0d: got %h expected 08", k, i_address); end
            checks++; if (if_id_instruction !== 32'hC0DE0004 || if_id_valid !== 1'b1) begin failures++; $display("[TB] FAIL stall_ifid%0d: got %h/%b expected c0de0004/1", k, if_id_instruction, if_id_valid); end
            checks++; if (in_hold !== 1'b1) begin failures++; $display("[TB] FAIL stall_hold%0d: got %b expected 1", k, in_hold); end
            checks++; if (stall_count !== 16'(k)) begin failures++; $display("[TB] FAIL stall_cnt%0d: got %0d expected %0d", k, stall_count, k); end
        end
        stall = 1'b0;
        step();
        checks++; if (i_address !== 8'h0C || in_hold !== 1'b0) begin failures++; $display("[TB] FAIL stall_resume: got %h/%b expected 0c/0", i_address, in_hold); end
        checks++; if (stall_count !== 16'd3) begin failures++; $display("[TB] FAIL stall_total: got %0d expected 3", stall_count); end
        checks++; if (if_id_instruction !== 32'hC0DE0008 || fetch_count !== 16'd3) begin failures++; $display("[TB] FAIL stall_reload: got %h/%0d expected c0de0008/3", if_id_instruction, fetch_count); end
    endtask

    task automatic test_branch_stall();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h23, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h20) begin failures++; $display("[TB] FAIL br_pc: got %h expected 20", i_address); end
        checks++; if (if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc_plus4 !== 8'h00) begin failures++; $display("[TB] FAIL br_squash: got %b/%h/%h expected 0/0/00", if_id_valid, if_id_instruction, if_id_pc_plus4); end
        checks++; if (in_hold !== 1'b0) begin failures++; $display("[TB] FAIL br_hold: got %b expected 0", in_hold); end
        checks++; if (fetch_count !== 16'd3 || stall_count !== 16'd3) begin failures++; $display("[TB] FAIL br_counts: got %0d/%0d expected 3/3", fetch_count, stall_count); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h24 || if_id_instruction !== 32'hC0DE0020 || if_id_pc_plus4 !== 8'h24) begin failures++; $display("[TB] FAIL br_after: got %h/%h/%h expected 24/c0de0020/24", i_address, if_id_instruction, if_id_pc_plus4); end
        checks++; if (fetch_count !== 16'd4) begin failures++; $display("[TB] FAIL br_after_cnt: got %0d expected 4", fetch_count); end
    endtask

    task automatic test_redirect_flush();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 8'h40, 1'b1, 8'h80);
        step();
        checks++; if (i_address !== 8'h40 || if_id_valid !== 1'b0) begin failures++; $display("[TB] FAIL brjmp: got %h/%b expected 40/0", i_address, if_id_valid); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'h87);
        step();
        checks++; if (i_address !== 8'h84 || if_id_valid !== 1'b0) begin failures++; $display("[TB] FAIL jmp_align: got %h/%b expected 84/0", i_address, if_id_valid); end
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h88 || if_id_valid !== 1'b0 || fetch_count !== 16'd4) begin failures++; $display("[TB] FAIL flush: got %h/%b/%0d expected 88/0/4", i_address, if_id_valid, fetch_count); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h8C || if_id_instruction !== 32'hC0DE0088 || fetch_count !== 16'd5) begin failures++; $display("[TB] FAIL flush_after: got %h/%h/%0d expected 8c/c0de0088/5", i_address, if_id_instruction, fetch_count); end
        applyStimulus(1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h8C || if_id_valid !== 1'b0 || in_hold !== 1'b1) begin failures++; $display("[TB] FAIL flush_stall: got %h/%b/%b expected 8c/0/1", i_address, if_id_valid, in_hold); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h90 || in_hold !== 1'b0 || stall_count !== 16'd4) begin failures++; $display("[TB] FAIL flush_stall_exit: got %h/%b/%0d expected 90/0/4", i_address, in_hold, stall_count); end
    endtask

    task automatic test_wrap();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 8'hFC);
        step();
        checks++; if (i_address !== 8'hFC) begin failures++; $display("[TB] FAIL wrap_setup: got %h expected fc", i_address); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h00) begin failures++; $display("[TB] FAIL wrap_pc: got %h expected 00", i_address); end
        checks++; if (if_id_pc_plus4 !== 8'h00 || if_id_instruction !== 32'hC0DE00FC || if_id_valid !== 1'b1) begin failures++; $display("[TB] FAIL wrap_ifid: got %h/%h/%b expected 00/c0de00fc/1", if_id_pc_plus4, if_id_instruction, if_id_valid); end
    endtask

    task automatic test_reset_mid_stall();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        for (int k = 0; k < 5; k++) step();
        stall = 1'b1;
        step();
        step();
        checks++; if (fetch_count !== 16'd5 || in_hold !== 1'b1 || stall_count !== 16'd1) begin failures++; $display("[TB] FAIL rst_setup: got %0d/%b/%0d expected 5/1/1", fetch_count, in_hold, stall_count); end
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 8'h60, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h00 || if_id_valid !== 1'b0 || if_id_instruction !== 32'h0 || if_id_pc_plus4 !== 8'h00) begin failures++; $display("[TB] FAIL rst_mid_ifid: got %h/%b/%h/%h expected 00/0/0/00", i_address, if_id_valid, if_id_instruction, if_id_pc_plus4); end
        checks++; if (fetch_count !== 16'd0 || stall_count !== 16'd0 || in_hold !== 1'b0) begin failures++; $display("[TB] FAIL rst_mid_state: got %0d/%0d/%b expected 0/0/0", fetch_count, stall_count, in_hold); end
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        checks++; if (i_address !== 8'h04 || if_id_instruction !== 32'hC0DE0000 || fetch_count !== 16'd1) begin failures++; $display("[TB] FAIL rst_first_fetch: got %h/%h/%0d expected 04/c0de0000/1", i_address, if_id_instruction, fetch_count); end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
        step();
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_redirect_flush();
        test_wrap();
        test_reset_mid_stall();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter RESET_PC, default 8'h00, PC value loaded on reset; SHALL be word-aligned.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 i_address  output  8  current PC, byte address driven to instruction memory.
REQ-005 instruction  input  32  combinational instruction-memory word for i_address.
REQ-006 stall  input  1  hold PC and IF/ID register.
REQ-007 flush  input  1  squash IF/ID contents.
REQ-008 branch_taken  input  1; branch_target  input  8  redirect from execute.
REQ-009 jump  input  1; jump_target  input  8  redirect from decode.
REQ-010 if_id_instruction  output  32; if_id_pc_plus4  output  8; if_id_valid  output  1  IF/ID register.
REQ-011 fetch_count  output  16  valid instructions delivered into IF/ID.
REQ-012 stall_count  output  16  cycles spent in HOLD.
REQ-013 in_hold  output  1  FSM is in HOLD.

Function
REQ-014 PC register SHALL drive i_address directly (no combinational path from inputs).
REQ-015 Next-PC priority SHALL be: branch_taken -> branch_target; else jump -> jump_target; else stall -> hold PC; else PC+4.
REQ-016 Redirect targets SHALL be force-aligned: bits [1:0] cleared.
REQ-017 PC+4 SHALL wrap modulo 256 (8'hFC + 4 = 8'h00); no overflow flag.
REQ-018 IF/ID update priority: branch_taken, jump, or flush -> if_id_valid=0, if_id_instruction=0, if_id_pc_plus4=0; else stall -> hold all three; else load instruction, PC+4, valid=1.
REQ-019 Redirect SHALL override stall in the same cycle (older instruction wins); both PC and IF/ID follow REQ-015/REQ-018.
REQ-020 branch_taken and jump together: branch_target SHALL be used; IF/ID squashed.
REQ-021 Fetch-to-IF/ID latency: instruction at PC N appears on if_id_instruction one cycle after i_address=N, when not stalled/squashed.
REQ-022 FSM states RUN, HOLD; RUN->HOLD when stall=1 and no redirect; HOLD->HOLD while stall=1 and no redirect; HOLD->RUN when stall=0 or redirect.
REQ-023 stall_count SHALL increment every cycle the FSM is in HOLD; saturates at 16'hFFFF.
REQ-024 fetch_count SHALL increment on each cycle IF/ID loads with valid=1; saturates at 16'hFFFF.
REQ-025 in_hold SHALL equal (state==HOLD), registered.

Reset
REQ-026 On reset=1 at a clock edge: PC=RESET_PC, IF/ID all zero, if_id_valid=0, fetch_count=0, stall_count=0, state=RUN, in_hold=0.
REQ-027 Reset SHALL dominate stall, flush, branch_taken, jump in the same cycle.
REQ-028 Reset mid-stall or mid-redirect SHALL discard pending action; first post-reset cycle fetches RESET_PC.

Verification
REQ-029 Reset then 4 free cycles, memory words W0..W3 at 0,4,8,12 -> i_address 0,4,8,12,16; if_id_instruction W0..W3 in cycles 2..5; fetch_count=4.
REQ-030 stall=1 for 3 cycles at PC=8 -> i_address stays 8, IF/ID holds W1, in_hold=1 cycles 2..4, stall_count=3; resumes PC=12.
REQ-031 branch_taken=1, branch_target=8'h23, with stall=1 -> next PC=8'h20, if_id_valid=0, in_hold stays 0, fetch_count unchanged.
REQ-032 branch_taken=1 target 8'h40 and jump=1 target 8'h80 same cycle -> PC=8'h40, IF/ID squashed.
REQ-033 PC=8'hFC free-running -> next i_address=8'h00, if_id_pc_plus4=8'h00 for the word fetched at 8'hFC.
REQ-034 reset asserted during stall with fetch_count=5 -> all outputs return to REQ-026 values next edge; next cycle i_address=RESET_PC.
